// File: rtl/board_state_controller_pkg.sv
// Shared constants for the lights-out board controller and check_for_win.
package board_state_controller_pkg;

    localparam int ROWS_DEF = 4;
    localparam int COLS_DEF = 8;

    // Galois LFSR tap mask, x^32 + x^22 + x^2 + x + 1
    localparam logic [31:0] LFSR_POLY = 32'h80200003;

    // Boards that check_for_win treats as solved
    localparam logic [31:0] WIN_ALL_OFF = 32'h00000000;
    localparam logic [31:0] WIN_ALL_ON  = 32'hFFFFFFFF;
    localparam logic [31:0] WIN_ALT_5   = 32'h55555555;
    localparam logic [31:0] WIN_ALT_A   = 32'hAAAAAAAA;

    // FSM encoding
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_SCRAMBLE = 2'd1;
    localparam logic [1:0] ST_PLAY     = 2'd2;
    localparam logic [1:0] ST_WON      = 2'd3;

    function automatic logic is_win_pattern(input logic [31:0] b);
        return (b == WIN_ALL_OFF) || (b == WIN_ALL_ON) ||
               (b == WIN_ALT_5)   || (b == WIN_ALT_A);
    endfunction

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

endpackage

// File: rtl/board_state_controller_if.sv
// Player-button / board-output bundle between the controller and its environment.
interface board_state_controller_if #(
    parameter int CELLS  = 32,
    parameter int MOVE_W = 10,
    parameter int IDX_W  = 5
);
    logic              btn_left;
    logic              btn_right;
    logic              btn_up;
    logic              btn_down;
    logic              btn_toggle;
    logic              btn_start;
    logic              win;
    logic [CELLS-1:0]  ScreenValues;
    logic [IDX_W-1:0]  cursor_idx;
    logic [MOVE_W-1:0] move_count;
    logic              playing;
    logic              stop;

    // Environment side: drives buttons and win, observes the board
    modport master (
        output btn_left, btn_right, btn_up, btn_down, btn_toggle, btn_start, win,
        input  ScreenValues, cursor_idx, move_count, playing, stop
    );

    // Controller side
    modport slave (
        input  btn_left, btn_right, btn_up, btn_down, btn_toggle, btn_start, win,
        output ScreenValues, cursor_idx, move_count, playing, stop
    );
endinterface

// File: rtl/board_state_controller_toggle_mask_gen.sv
// Combinational (row,col) -> mask of the cell and its existing orthogonal
// neighbours. COLS must be a power of two so {row,col} is the cell index.
module toggle_mask_gen #(
    parameter int ROWS = 4,
    parameter int COLS = 8
) (
    input  logic [$clog2(ROWS)-1:0]      row_i,
    input  logic [$clog2(COLS)-1:0]      col_i,
    output logic [ROWS*COLS-1:0]         mask_o
);
    localparam int RW    = $clog2(ROWS);
    localparam int CW    = $clog2(COLS);
    localparam int IDX_W = $clog2(ROWS*COLS);

    logic [IDX_W-1:0] idx;
    assign idx = {row_i, col_i};

    // Set the centre bit, then each neighbour that lies on the board (no wrap)
    always_comb begin
        mask_o      = '0;
        mask_o[idx] = 1'b1;
        if (row_i != '0)              mask_o[idx - IDX_W'(COLS)] = 1'b1;
        if (row_i != RW'(ROWS - 1))   mask_o[idx + IDX_W'(COLS)] = 1'b1;
        if (col_i != '0)              mask_o[idx - 1'b1]         = 1'b1;
        if (col_i != CW'(COLS - 1))   mask_o[idx + 1'b1]         = 1'b1;
    end
endmodule

// File: rtl/board_state_controller.sv
// Lights-out board owner: button edge detect, free-running LFSR, game FSM,
// cursor, board register and saturating move counter.
module board_state_controller
    import board_state_controller_pkg::*;
#(
    parameter int          ROWS         = ROWS_DEF,
    parameter int          COLS         = COLS_DEF,
    parameter int          NumberOfBits = 31,
    parameter logic [31:0] SEED         = 32'hACE12B5D,
    parameter logic [31:0] RESET_BOARD  = 32'h00000018,
    parameter int          MOVE_W       = 10
) (
    input  logic                    clk,
    input  logic                    reset_n,
    board_state_controller_if.slave bus
);
    localparam int          CELLS    = ROWS * COLS;
    localparam int          RW       = $clog2(ROWS);
    localparam int          CW       = $clog2(COLS);
    localparam int          IDX_W    = $clog2(CELLS);
    localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;

    // Button bit positions in the packed level/pulse vectors
    localparam int B_LEFT = 0, B_RIGHT = 1, B_UP = 2, B_DOWN = 3, B_TOG = 4, B_START = 5;

    logic [5:0]              btn_lvl, btn_prev_q, pulse;
    logic [1:0]              state_q, state_d;
    logic [NumberOfBits:0]   board_q, board_d;
    logic [RW-1:0]           row_q, row_d, m_row;
    logic [CW-1:0]           col_q, col_d, m_col;
    logic [MOVE_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]        k_q, k_d;
    logic [31:0]             lfsr_q;
    logic [CELLS-1:0]        mask;
    logic                    scr;

    assign btn_lvl = {bus.btn_start, bus.btn_toggle, bus.btn_down,
                      bus.btn_up, bus.btn_right, bus.btn_left};
    assign pulse   = btn_lvl & ~btn_prev_q;

    // One mask generator serves both the scramble scan and the player cursor
    assign scr   = (state_q == ST_SCRAMBLE);
    assign m_row = scr ? k_q[IDX_W-1:CW] : row_q;
    assign m_col = scr ? k_q[CW-1:0]     : col_q;

    toggle_mask_gen #(.ROWS(ROWS), .COLS(COLS)) u_mask (
        .row_i  (m_row),
        .col_i  (m_col),
        .mask_o (mask)
    );

    // Next-state logic for FSM, board, cursor, move counter and scan index
    always_comb begin
        state_d = state_q;
        board_d = board_q;
        row_d   = row_q;
        col_d   = col_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
        case (state_q)
            ST_IDLE: begin
                if (pulse[B_START]) begin
                    state_d = ST_SCRAMBLE;
                    cnt_d   = '0;
                    k_d     = '0;
                end
            end
            ST_SCRAMBLE: begin
                cnt_d = '0;
                if (lfsr_q[0]) board_d = board_q ^ mask;
                if (k_q == IDX_W'(CELLS - 1)) begin
                    // A pass that lands on a solved board is repeated
                    k_d = '0;
                    if (!is_win_pattern(board_d)) begin
                        state_d = ST_PLAY;
                        row_d   = '0;
                        col_d   = '0;
                    end
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            ST_PLAY: begin
                if (pulse[B_START]) begin
                    state_d = ST_SCRAMBLE;
                    cnt_d   = '0;
                    k_d     = '0;
                end else if (bus.win) begin
                    state_d = ST_WON;
                end else begin
                    // Toggle uses the cursor before this cycle's move
                    if (pulse[B_TOG]) begin
                        board_d = board_q ^ mask;
                        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                    end
                    if (pulse[B_LEFT] && !pulse[B_RIGHT] && col_q != '0)
                        col_d = col_q - 1'b1;
                    else if (pulse[B_RIGHT] && !pulse[B_LEFT] && col_q != CW'(COLS - 1))
                        col_d = col_q + 1'b1;
                    if (pulse[B_UP] && !pulse[B_DOWN] && row_q != '0)
                        row_d = row_q - 1'b1;
                    else if (pulse[B_DOWN] && !pulse[B_UP] && row_q != RW'(ROWS - 1))
                        row_d = row_q + 1'b1;
                end
            end
            default: begin  // ST_WON: everything frozen until a new game
                if (pulse[B_START]) begin
                    state_d = ST_SCRAMBLE;
                    cnt_d   = '0;
                    k_d     = '0;
                end
            end
        endcase
    end

    // State registers; LFSR and button history run every cycle
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            board_q    <= RESET_BOARD[NumberOfBits:0];
            row_q      <= '0;
            col_q      <= '0;
            cnt_q      <= '0;
            k_q        <= '0;
            lfsr_q     <= SEED_EFF;
            btn_prev_q <= '0;
        end else begin
            state_q    <= state_d;
            board_q    <= board_d;
            row_q      <= row_d;
            col_q      <= col_d;
            cnt_q      <= cnt_d;
            k_q        <= k_d;
            lfsr_q     <= lfsr_step(lfsr_q);
            btn_prev_q <= btn_lvl;
        end
    end

    assign bus.ScreenValues = board_q;
    assign bus.cursor_idx   = {row_q, col_q};
    assign bus.move_count   = cnt_q;
    assign bus.playing      = (state_q == ST_PLAY);
    assign bus.stop         = (state_q == ST_IDLE) || (state_q == ST_SCRAMBLE);

endmodule
